// File: rtl/paddle_move_if.sv
// Command/position bundle between a paddle driver (auto player or button
// decoder) and the paddle_move integrator.
interface paddle_move_if;
  logic       tick;
  logic       freeze;
  logic       center;
  logic       p;
  logic       m;
  logic [9:0] py;
  logic [1:0] dir;
  logic       at_min;
  logic       at_max;

  modport master (
    output tick, freeze, center, p, m,
    input  py, dir, at_min, at_max
  );

  modport slave (
    input  tick, freeze, center, p, m,
    output py, dir, at_min, at_max
  );
endinterface

// File: rtl/paddle_move.sv
// Paddle centre integrator: clamped per-tick moves from active-low p/m requests.
// Define PADDLE_MOVE_ACCEL_EN to enable the hold counter and the fast phase.
module paddle_move #(
  parameter int unsigned PADDLE_H    = 80,
  parameter int unsigned Y_MAX       = 479,
  parameter int unsigned CENTER_Y    = 240,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned FAST_SPEED  = 6,
  parameter int unsigned ACCEL_TICKS = 8
) (
  input  logic        clk,
  input  logic        rst,
  paddle_move_if.slave bus
);

  localparam logic [10:0] PY_MIN    = 11'(PADDLE_H / 2);
  localparam logic [10:0] PY_MAX    = 11'(Y_MAX - PADDLE_H / 2);
  localparam logic [9:0]  CENTER    = 10'(CENTER_Y);
  localparam logic [10:0] STEP_SLOW = 11'(SPEED);

  if ((PADDLE_H % 2) != 0 || ACCEL_TICKS < 1 || ACCEL_TICKS > 15 || FAST_SPEED == 0) begin : gBadConfig
    $error("paddle_move: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    INC_ST = 2'b01,
    DEC_ST = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  py_q, py_d;
  logic        atMin_q, atMax_q;
  logic        cmdInc, cmdDec;
  logic        moveInc, moveDec;
  logic [10:0] step;
  logic [10:0] pyWide;
  logic [10:0] sum;

  // p=m=0 is the auto player's reset pattern, so it decodes as HOLD like p=m=1
  assign cmdInc = !bus.p && bus.m;
  assign cmdDec = bus.p && !bus.m;

  always_comb begin
    state_d = state_q;
    moveInc = 1'b0;
    moveDec = 1'b0;
    if (bus.center) begin
      state_d = IDLE;
    end else if (bus.tick) begin
      if (bus.freeze || !(cmdInc || cmdDec)) begin
        state_d = IDLE;
      end else if (cmdInc) begin
        state_d = INC_ST;
        moveInc = 1'b1;
      end else begin
        state_d = DEC_ST;
        moveDec = 1'b1;
      end
    end
  end

`ifdef PADDLE_MOVE_ACCEL_EN
  localparam logic [3:0]  ACCEL_CNT = 4'(ACCEL_TICKS);
  localparam logic [10:0] STEP_FAST = 11'(FAST_SPEED);

  logic [3:0] count_q, count_d;
  logic       sameDir;

  // A reversal restarts the run, so only a continuing direction may go fast
  always_comb begin
    sameDir = (moveInc && state_q == INC_ST) || (moveDec && state_q == DEC_ST);
    step    = (sameDir && count_q == ACCEL_CNT) ? STEP_FAST : STEP_SLOW;
    count_d = count_q;
    if (state_d == IDLE) begin
      count_d = 4'd0;
    end else if (moveInc || moveDec) begin
      if (!sameDir) begin
        count_d = 4'd1;
      end else if (count_q != ACCEL_CNT) begin
        count_d = count_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end
`else
  assign step = STEP_SLOW;
`endif

  assign pyWide = {1'b0, py_q};
  assign sum    = pyWide + step;

  always_comb begin
    py_d = py_q;
    if (bus.center) begin
      py_d = CENTER;
    end else if (moveInc) begin
      py_d = (sum > PY_MAX) ? 10'(PY_MAX) : sum[9:0];
    end else if (moveDec) begin
      py_d = (pyWide < PY_MIN + step) ? 10'(PY_MIN) : py_q - step[9:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      py_q    <= CENTER;
      atMin_q <= 1'b0;
      atMax_q <= 1'b0;
    end else begin
      state_q <= state_d;
      py_q    <= py_d;
      atMin_q <= (py_d == 10'(PY_MIN));
      atMax_q <= (py_d == 10'(PY_MAX));
    end
  end

  assign bus.py     = py_q;
  assign bus.dir    = state_q;
  assign bus.at_min = atMin_q;
  assign bus.at_max = atMax_q;

endmodule

// File: tb/tb_paddle_move.sv
// Self-checking bench for paddle_move: directed table, corner sequences and
// randomized traffic checked against a position/run-length model.
module tb_paddle_move;

`ifdef PADDLE_MOVE_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  localparam int PY_MIN = 40;
  localparam int PY_MAX = 439;
  localparam int CENTER_Y = 240;

  logic clk;
  logic rst;
  paddle_move_if bus ();

  paddle_move dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Model: position, direction (0 idle, 1 inc, 2 dec), ticks already spent in it
  int mPy = CENTER_Y;
  int mDir = 0;
  int mRun = 0;

  typedef struct {
    logic tick;
    logic freeze;
    logic center;
    logic p;
    logic m;
    int   expPy;
    int   expDir;
  } vec_t;

  vec_t vecs[16];

  task automatic modelStep(input logic t, input logic f, input logic c, input logic pp, input logic mm);
    int run;
    int step;
    if (c) begin
      mPy = CENTER_Y; mDir = 0; mRun = 0;
    end else if (t) begin
      if (f || (pp == mm)) begin
        mDir = 0; mRun = 0;
      end else begin
        run  = ((pp == 1'b0 && mDir == 1) || (mm == 1'b0 && mDir == 2)) ? mRun : 0;
        step = (ACCEL && run >= 8) ? 6 : 2;
        if (pp == 1'b0) begin
          mPy = (mPy + step > PY_MAX) ? PY_MAX : mPy + step;
          mDir = 1;
        end else begin
          mPy = (mPy - step < PY_MIN) ? PY_MIN : mPy - step;
          mDir = 2;
        end
        mRun = run + 1;
      end
    end
  endtask

  task automatic compareVal(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    compareVal({tag, ".py"}, int'(bus.py), mPy);
    compareVal({tag, ".dir"}, int'(bus.dir), mDir);
    compareVal({tag, ".at_min"}, int'(bus.at_min), int'(mPy == PY_MIN));
    compareVal({tag, ".at_max"}, int'(bus.at_max), int'(mPy == PY_MAX));
  endtask

  // Inputs change just after a falling edge; outputs are sampled on the next one
  task automatic applyStimulus(input logic t, input logic f, input logic c, input logic pp, input logic mm);
    bus.tick = t; bus.freeze = f; bus.center = c; bus.p = pp; bus.m = mm;
    @(posedge clk);
    modelStep(t, f, c, pp, mm);
    @(negedge clk);
  endtask

  initial begin
    int savedPy;

    for (int i = 0; i < 12; i++) begin
      vecs[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                  (ACCEL && i >= 8) ? 256 + 6 * (i - 7) : 242 + 2 * i, 1};
    end
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ACCEL ? 280 : 264, 0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ACCEL ? 280 : 264, 0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ACCEL ? 278 : 262, 2};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ACCEL ? 276 : 260, 2};

    rst = 1'b0;
    bus.tick = 1'b0; bus.freeze = 1'b0; bus.center = 1'b0; bus.p = 1'b1; bus.m = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].tick, vecs[i].freeze, vecs[i].center, vecs[i].p, vecs[i].m);
      compareVal($sformatf("table[%0d].py", i), int'(bus.py), vecs[i].expPy);
      compareVal($sformatf("table[%0d].dir", i), int'(bus.dir), vecs[i].expDir);
      checkOutput($sformatf("table_model[%0d]", i));
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1;
    mPy = CENTER_Y; mDir = 0; mRun = 0;
    compareVal("async_reset.py", int'(bus.py), 240);
    checkOutput("async_reset");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    compareVal("pm_low_hold.py", int'(bus.py), 240);
    checkOutput("pm_low_hold");

    for (int i = 0; i < 220; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    compareVal("clamp_top.py", int'(bus.py), 439);
    compareVal("clamp_top.at_max", int'(bus.at_max), 1);
    compareVal("clamp_top.dir", int'(bus.dir), 1);
    checkOutput("clamp_top");

    for (int i = 0; i < 220; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    compareVal("clamp_bot.py", int'(bus.py), 40);
    compareVal("clamp_bot.at_min", int'(bus.at_min), 1);
    compareVal("clamp_bot.dir", int'(bus.dir), 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    compareVal("reverse1.py", int'(bus.py), 42);
    compareVal("reverse1.at_min", int'(bus.at_min), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    compareVal("reverse2.py", int'(bus.py), 44);
    checkOutput("reverse");

    savedPy = mPy;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    compareVal("freeze.py", int'(bus.py), savedPy);
    compareVal("freeze.dir", int'(bus.dir), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    compareVal("center_notick.py", int'(bus.py), 240);
    compareVal("center_notick.dir", int'(bus.dir), 0);

    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    compareVal("no_tick.py", int'(bus.py), 240);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    compareVal("single_tick.py", int'(bus.py), 242);
    checkOutput("single_tick");

    for (int i = 0; i < 1500; i++) begin
      logic t, f, c, pp, mm;
      int mode;
      t  = ($urandom_range(0, 99) < 60);
      f  = ($urandom_range(0, 99) < 8);
      c  = ($urandom_range(0, 99) < 3);
      mode = $urandom_range(0, 9);
      pp = (mode < 4) ? 1'b0 : (mode < 8) ? 1'b1 : 1'(mode[0]);
      mm = (mode < 4) ? 1'b1 : (mode < 8) ? 1'b0 : 1'(mode[0]);
      applyStimulus(t, f, c, pp, mm);
      checkOutput($sformatf("random[%0d]", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
